// File: rtl/updown_tick_counter_pkg.sv
// Shared types and default sizing for the up/down tick counter family.
// Also used by the reusable tick prescaler.
package updown_tick_counter_pkg;

    typedef enum logic {
        CNT_UP = 1'b0,
        CNT_DN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int unsigned DEF_WIDTH    = 18;
    localparam int unsigned DEF_PRESCALE = 4;

endpackage

// File: rtl/updown_tick_counter_tick_prescaler.sv
// Clock-enable prescaler: TICK is high for one CLK cycle every PRESCALE enabled cycles.
// Intended for reuse by UART and timer blocks.
module tick_prescaler
    import updown_tick_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned PS_W     = $clog2(PRESCALE + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] p;

    // With PRESCALE=1, LAST is 0 and p never leaves 0, so TICK follows EN.
    assign TICK = EN && (p == LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            p <= '0;
        end else if (TICK) begin
            p <= '0;
        end else if (EN) begin
            p <= p + PS_W'(1);
        end
    end

endmodule

// File: rtl/updown_tick_counter.sv
// Prescaled up/down counter with programmable inclusive limit, parallel load,
// wrap/saturate mode, a registered terminal-count pulse and a sticky overflow flag.
module updown_tick_counter
    import updown_tick_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned PS_W     = $clog2(PRESCALE + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIR,
    input  logic             SAT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic [WIDTH-1:0] MAX_VAL,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] OUT,
    output logic             TICK,
    output logic             TC,
    output logic             OVF
);

    dir_e             dir;
    dir_e             dir_q;
    mode_e            mode;
    logic             at_limit;
    logic             at_limit_held;
    logic             at_limit_next;
    logic             tc_next;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] load_clamped;

    assign dir  = dir_e'(DIR);
    assign mode = mode_e'(SAT);

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .TICK (TICK)
    );

    assign load_clamped = (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;

    // A direction change since the last edge forgets any earlier saturation hit,
    // even when a tick lands on the same edge.
    assign at_limit_held = at_limit && (dir == dir_q);

    always_comb begin
        out_next      = OUT;
        tc_next       = 1'b0;
        at_limit_next = at_limit_held;
        if (LOAD) begin
            out_next      = load_clamped;
            at_limit_next = 1'b0;
        end else if (TICK) begin
            if (dir == CNT_UP) begin
                if (OUT < MAX_VAL) begin
                    out_next      = OUT + WIDTH'(1);
                    at_limit_next = 1'b0;
                end else if (mode == MODE_WRAP) begin
                    out_next      = '0;
                    tc_next       = 1'b1;
                    at_limit_next = 1'b0;
                end else begin
                    out_next      = MAX_VAL;
                    tc_next       = (OUT != MAX_VAL) || !at_limit_held;
                    at_limit_next = 1'b1;
                end
            end else begin
                if (OUT > MAX_VAL) begin
                    out_next      = MAX_VAL;
                    at_limit_next = 1'b0;
                end else if (OUT != '0) begin
                    out_next      = OUT - WIDTH'(1);
                    at_limit_next = 1'b0;
                end else if (mode == MODE_WRAP) begin
                    out_next      = MAX_VAL;
                    tc_next       = 1'b1;
                    at_limit_next = 1'b0;
                end else begin
                    out_next      = '0;
                    tc_next       = !at_limit_held;
                    at_limit_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            OUT      <= (dir == CNT_DN) ? MAX_VAL : '0;
            TC       <= 1'b0;
            OVF      <= 1'b0;
            at_limit <= 1'b0;
            dir_q    <= dir;
        end else begin
            OUT      <= out_next;
            TC       <= tc_next;
            OVF      <= tc_next || (OVF && !CLR_OVF);
            at_limit <= at_limit_next;
            dir_q    <= dir;
        end
    end

endmodule
